// File: rtl/spi_txn_arbiter_if.sv
// rtl/spi_txn_arbiter_if.sv - requester and SPI-master side signals of the transaction arbiter
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_tx_data;
    logic [NUM_REQ*2-1:0]          req_slave_sel;
    logic [NUM_REQ*2-1:0]          req_mode;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_err;
    logic                          busy;
    logic                          m_start;
    logic [DATA_WIDTH-1:0]         m_tx_data;
    logic [1:0]                    m_slave_sel;
    logic                          m_cpol;
    logic                          m_cpha;
    logic                          m_done;
    logic [DATA_WIDTH-1:0]         m_rx_data;

    modport slave (
        input  req, req_tx_data, req_slave_sel, req_mode, m_done, m_rx_data,
        output gnt, rsp_valid, rsp_data, rsp_err, busy,
               m_start, m_tx_data, m_slave_sel, m_cpol, m_cpha
    );

    modport master (
        output req, req_tx_data, req_slave_sel, req_mode, m_done, m_rx_data,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy,
               m_start, m_tx_data, m_slave_sel, m_cpol, m_cpha
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin scheduler sharing one SPI master between requesters
module spi_txn_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_SLAVES     = 3,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    spi_txn_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PTR_W:0]   NREQ_W   = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [2:0]       NSLV     = 3'(NUM_SLAVES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_BUSY   = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    logic [2:0]            r_state;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_m_start;
    logic [DATA_WIDTH-1:0] r_m_tx_data;
    logic [1:0]            r_m_slave_sel;
    logic                  r_m_cpol;
    logic                  r_m_cpha;
    logic [TO_W-1:0]       r_to_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;

    logic [DATA_WIDTH-1:0] w_tx   [NUM_REQ];
    logic [1:0]            w_sel  [NUM_REQ];
    logic [1:0]            w_mode [NUM_REQ];
    logic [PTR_W:0]        w_sum  [NUM_REQ];
    logic [PTR_W-1:0]      w_cand [NUM_REQ];
    logic                  w_found;
    logic [PTR_W-1:0]      w_winner;
    logic [PTR_W-1:0]      w_ptr_next;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic                  w_sel_bad;
    logic [TO_W-1:0]       w_to_next;

    // w_cand[k] is the requester k positions after rr_ptr, wrapped at NUM_REQ
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
        assign w_tx[k]   = bus.req_tx_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_sel[k]  = bus.req_slave_sel[2*k +: 2];
        assign w_mode[k] = bus.req_mode[2*k +: 2];
        assign w_sum[k]  = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
        assign w_cand[k] = (w_sum[k] >= NREQ_W) ? PTR_W'(w_sum[k] - NREQ_W)
                                                : w_sum[k][PTR_W-1:0];
    end

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[w_cand[k]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[k];
            end
        end
    end

    always_comb begin
        w_gnt_oh           = '0;
        w_gnt_oh[w_winner] = 1'b1;
    end

    assign w_ptr_next = (w_winner == PTR_LAST) ? '0 : w_winner + PTR_W'(1);
    assign w_sel_bad  = ({1'b0, w_sel[w_winner]} >= NSLV);
    assign w_to_next  = r_to_cnt + TO_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_gnt         <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_m_start     <= 1'b0;
            r_m_tx_data   <= '0;
            r_m_slave_sel <= '0;
            r_m_cpol      <= 1'b0;
            r_m_cpha      <= 1'b0;
            r_to_cnt      <= '0;
            r_gap_cnt     <= '0;
        end else begin
            r_m_start   <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_gnt_oh;
                        r_rr_ptr <= w_ptr_next;
                        // a bad slave code never reaches the master, so its settings stay put
                        if (w_sel_bad) begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            r_m_tx_data   <= w_tx[w_winner];
                            r_m_slave_sel <= w_sel[w_winner];
                            r_m_cpol      <= w_mode[w_winner][1];
                            r_m_cpha      <= w_mode[w_winner][0];
                            r_state       <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_m_start <= 1'b1;
                    r_to_cnt  <= '0;
                    r_state   <= S_BUSY;
                end
                S_BUSY: begin
                    if (bus.m_done) begin
                        r_rsp_data <= bus.m_rx_data;
                        r_rsp_err  <= 1'b0;
                        r_state    <= S_RESP;
                    end else if (w_to_next == TO_LAST) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_to_cnt <= w_to_next;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= r_gnt;
                    r_gnt       <= '0;
                    r_gap_cnt   <= GAP_LOAD;
                    r_state     <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.m_start     = r_m_start;
    assign bus.m_tx_data   = r_m_tx_data;
    assign bus.m_slave_sel = r_m_slave_sel;
    assign bus.m_cpol      = r_m_cpol;
    assign bus.m_cpha      = r_m_cpha;
endmodule
